// File: rtl/weight_fetch_unit_pkg.sv
// Shared constants and state type for the weight fetch stage.
// WEIGHT_PREFETCH_EN selects double buffering (NBUF=2); the default build is single buffered.
package tpu_package;

    localparam int MUL_SIZE      = 32;
    localparam int WEIGHT_ADDR_W = 16;

`ifdef WEIGHT_PREFETCH_EN
    localparam int WEIGHT_NBUF = 2;
`else
    localparam int WEIGHT_NBUF = 1;
`endif

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WAIT_FREE,
        DRAIN
    } weight_fetch_state_t;

endpackage

// File: rtl/weight_fetch_unit_addr_gen.sv
// Row/tile counters and weight-memory row address for the weight fetch stage.
module weight_addr_gen #(
    parameter int MUL_SIZE = 32,
    parameter int ADDR_W   = 16,
    parameter int TILE_W   = 9
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        load_i,
    input  logic [ADDR_W-1:0]           base_i,
    input  logic [TILE_W-1:0]           tiles_i,
    input  logic                        adv_i,
    output logic [ADDR_W-1:0]           addr_o,
    output logic [$clog2(MUL_SIZE)-1:0] row_o,
    output logic                        last_row_o,
    output logic                        last_tile_o
);

    localparam int RW = $clog2(MUL_SIZE);

    logic [ADDR_W-1:0] base_q;
    logic [TILE_W-1:0] tiles_q;
    logic [TILE_W-1:0] tile_q;
    logic [RW-1:0]     row_q;
    logic [ADDR_W-1:0] tile_off;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            base_q  <= '0;
            tiles_q <= '0;
            tile_q  <= '0;
            row_q   <= '0;
        end else if (load_i) begin
            base_q  <= base_i;
            tiles_q <= tiles_i;
            tile_q  <= '0;
            row_q   <= '0;
        end else if (adv_i) begin
            if (last_row_o) begin
                row_q  <= '0;
                tile_q <= tile_q + TILE_W'(1);
            end else begin
                row_q <= row_q + RW'(1);
            end
        end
    end

    assign last_row_o  = (row_q == RW'(MUL_SIZE - 1));
    assign last_tile_o = (tile_q == tiles_q - TILE_W'(1));
    assign row_o       = row_q;

    // Address arithmetic wraps modulo 2^ADDR_W by truncation.
    assign tile_off = ADDR_W'(tile_q) * ADDR_W'(MUL_SIZE);
    assign addr_o   = base_q + tile_off + ADDR_W'(row_q);

endmodule

// File: rtl/weight_fetch_unit.sv
// Weight tile fetch stage: streams MUL_SIZE x MUL_SIZE tiles into the MAC weight registers.
// WEIGHT_PREFETCH_EN enables ping/pong double buffering; otherwise one buffer and buf_sel tied 0.
module weight_fetch_unit #(
    parameter int MUL_SIZE = tpu_package::MUL_SIZE,
    parameter int ADDR_W   = tpu_package::WEIGHT_ADDR_W,
    parameter int TILE_W   = 9
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [ADDR_W-1:0]           W_base_addr_i,
    input  logic [TILE_W-1:0]           W_tiles_i,
    input  logic                        next_weight_tile_i,
    output logic                        wmem_rd_en_o,
    output logic [ADDR_W-1:0]           wmem_addr_o,
    input  logic [MUL_SIZE*8-1:0]       wmem_data_i,
    output logic [MUL_SIZE*8-1:0]       weight_row_o,
    output logic                        weight_row_valid_o,
    output logic [$clog2(MUL_SIZE)-1:0] weight_row_idx_o,
    output logic                        weight_buf_sel_o,
    output logic                        compute_weights_rdy_o,
    output logic                        done_o,
    output logic                        underflow_err_o
);

    import tpu_package::*;

    localparam int RW = $clog2(MUL_SIZE);
    localparam logic [RW-1:0] LAST_ROW = RW'(MUL_SIZE - 1);

    weight_fetch_state_t state;

    logic [1:0]        full_cnt;
    logic [2:0]        occ;
    logic              accept;
    logic              tile_done;
    logic              take;
    logic              fill_more;
    logic              wait_ok;
    logic              last_row;
    logic              last_tile;
    logic [RW-1:0]     row;
    logic [ADDR_W-1:0] addr;

    weight_addr_gen #(
        .MUL_SIZE (MUL_SIZE),
        .ADDR_W   (ADDR_W),
        .TILE_W   (TILE_W)
    ) u_addr_gen (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (accept),
        .base_i      (W_base_addr_i),
        .tiles_i     (W_tiles_i),
        .adv_i       (wmem_rd_en_o),
        .addr_o      (addr),
        .row_o       (row),
        .last_row_o  (last_row),
        .last_tile_o (last_tile)
    );

    assign accept    = start_i && (state == IDLE);
    assign tile_done = weight_row_valid_o && (weight_row_idx_o == LAST_ROW);
    assign take      = next_weight_tile_i && (full_cnt != 2'd0);

    // A tile whose last row is still in flight already owns a buffer.
    assign occ       = {1'b0, full_cnt} + {2'b00, tile_done};
    assign fill_more = (occ + 3'd1) < 3'(WEIGHT_NBUF);
    assign wait_ok   = occ < 3'(WEIGHT_NBUF);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= IDLE;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        if (W_tiles_i != '0) state <= FILL;
                        else                 done_o <= 1'b1;
                    end
                end
                FILL: begin
                    if (last_row) begin
                        if (last_tile)       state <= DRAIN;
                        else if (!fill_more) state <= WAIT_FREE;
                    end
                end
                WAIT_FREE: begin
                    if (wait_ok) state <= FILL;
                end
                DRAIN: begin
                    if (occ == 3'd0) begin
                        done_o <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            weight_row_valid_o <= 1'b0;
            weight_row_idx_o   <= '0;
            full_cnt           <= '0;
            underflow_err_o    <= 1'b0;
        end else begin
            weight_row_valid_o <= wmem_rd_en_o;
            if (wmem_rd_en_o) weight_row_idx_o <= row;
            if (tile_done && !take)      full_cnt <= full_cnt + 2'd1;
            else if (take && !tile_done) full_cnt <= full_cnt - 2'd1;
            if (accept) underflow_err_o <= 1'b0;
            if (next_weight_tile_i && (full_cnt == 2'd0)) underflow_err_o <= 1'b1;
        end
    end

`ifdef WEIGHT_PREFETCH_EN
    logic buf_sel_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)         buf_sel_q <= 1'b0;
        else if (tile_done) buf_sel_q <= ~buf_sel_q;
    end

    assign weight_buf_sel_o = buf_sel_q;
`else
    assign weight_buf_sel_o = 1'b0;
`endif

    assign wmem_rd_en_o          = (state == FILL);
    assign wmem_addr_o           = wmem_rd_en_o ? addr : '0;
    assign weight_row_o          = {(MUL_SIZE*8){weight_row_valid_o}} & wmem_data_i;
    assign compute_weights_rdy_o = (full_cnt != 2'd0);

endmodule

// File: tb/tb_weight_fetch_unit.sv
// Directed bench for weight_fetch_unit; memory returns the read address as data.
// Compile with WEIGHT_PREFETCH_EN to exercise the double-buffered build.
module tb_weight_fetch_unit;

    localparam int MS = 32;
    localparam int AW = 16;
    localparam int TW = 9;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b0;
    logic            start_i = 1'b0;
    logic [AW-1:0]   W_base_addr_i = '0;
    logic [TW-1:0]   W_tiles_i = '0;
    logic            next_weight_tile_i = 1'b0;
    logic            wmem_rd_en_o;
    logic [AW-1:0]   wmem_addr_o;
    logic [MS*8-1:0] wmem_data_i = '0;
    logic [MS*8-1:0] weight_row_o;
    logic            weight_row_valid_o;
    logic [4:0]      weight_row_idx_o;
    logic            weight_buf_sel_o;
    logic            compute_weights_rdy_o;
    logic            done_o;
    logic            underflow_err_o;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    int unsigned rd_cnt  = 0;

    weight_fetch_unit #(
        .MUL_SIZE (MS),
        .ADDR_W   (AW),
        .TILE_W   (TW)
    ) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .start_i               (start_i),
        .W_base_addr_i         (W_base_addr_i),
        .W_tiles_i             (W_tiles_i),
        .next_weight_tile_i    (next_weight_tile_i),
        .wmem_rd_en_o          (wmem_rd_en_o),
        .wmem_addr_o           (wmem_addr_o),
        .wmem_data_i           (wmem_data_i),
        .weight_row_o          (weight_row_o),
        .weight_row_valid_o    (weight_row_valid_o),
        .weight_row_idx_o      (weight_row_idx_o),
        .weight_buf_sel_o      (weight_buf_sel_o),
        .compute_weights_rdy_o (compute_weights_rdy_o),
        .done_o                (done_o),
        .underflow_err_o       (underflow_err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        wmem_data_i <= wmem_rd_en_o ? 256'(wmem_addr_o) : '0;
        if (wmem_rd_en_o) rd_cnt <= rd_cnt + 1;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Returns at the negedge of cycle 0 (start sampled at edge 0).
    task automatic start_job(input logic [AW-1:0] base, input logic [TW-1:0] tiles);
        @(negedge clk_i);
        start_i       = 1'b1;
        W_base_addr_i = base;
        W_tiles_i     = tiles;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    // Returns at the negedge of the cycle right after the sampling edge.
    task automatic pulse_next();
        @(negedge clk_i);
        next_weight_tile_i = 1'b1;
        @(negedge clk_i);
        next_weight_tile_i = 1'b0;
    endtask

    task automatic wait_rdy();
        int unsigned n = 0;
        while (!compute_weights_rdy_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check("rdy_wait", compute_weights_rdy_o, 1'b1);
    endtask

    task automatic wait_done();
        int unsigned n = 0;
        while (!done_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check("done_wait", done_o, 1'b1);
        @(negedge clk_i);
        check("done_single", done_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] ea;
        int unsigned   rd_snap;

        // Reset state
        repeat (2) @(negedge clk_i);
        check("rst_rd_en", wmem_rd_en_o, 1'b0);
        check("rst_addr", wmem_addr_o, '0);
        check("rst_row", weight_row_o, '0);
        check("rst_valid", weight_row_valid_o, 1'b0);
        check("rst_idx", weight_row_idx_o, '0);
        check("rst_bufsel", weight_buf_sel_o, 1'b0);
        check("rst_rdy", compute_weights_rdy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_uflow", underflow_err_o, 1'b0);
        rst_i = 1'b1;

        // Reset asserted mid-fill
        start_job(16'h0100, 9'd1);
        repeat (5) @(negedge clk_i);
        check("midfill_rd_en", wmem_rd_en_o, 1'b1);
        rst_i = 1'b0;
        #1;
        check("arst_rd_en", wmem_rd_en_o, 1'b0);
        check("arst_valid", weight_row_valid_o, 1'b0);
        check("arst_row", weight_row_o, '0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("post_rst_rd_en", wmem_rd_en_o, 1'b0);
        check("post_rst_rdy", compute_weights_rdy_o, 1'b0);
        check("post_rst_idx", weight_row_idx_o, '0);

        // Single tile at 0x0100, cycle-exact
        start_job(16'h0100, 9'd1);
        for (int unsigned k = 0; k <= 33; k++) begin
            if (k > 0) @(negedge clk_i);
            check("t1_rd_en", wmem_rd_en_o, k <= 31);
            if (k <= 31) check("t1_addr", wmem_addr_o, 16'h0100 + k);
            check("t1_valid", weight_row_valid_o, (k >= 1) && (k <= 32));
            if (k >= 1 && k <= 32) begin
                check("t1_idx", weight_row_idx_o, k - 1);
                check("t1_row", weight_row_o, 16'h0100 + k - 1);
            end
            check("t1_rdy", compute_weights_rdy_o, k >= 33);
            check("t1_bufsel_nodone", done_o, 1'b0);
        end
        pulse_next();
        check("t1_rdy_after_free", compute_weights_rdy_o, 1'b0);
        check("t1_done_not_yet", done_o, 1'b0);
        @(negedge clk_i);
        check("t1_done", done_o, 1'b1);
        @(negedge clk_i);
        check("t1_done_once", done_o, 1'b0);
        check("t1_idle", wmem_rd_en_o, 1'b0);
        check("t1_uflow", underflow_err_o, 1'b0);

        // Underflow while idle, cleared by next start; empty job
        pulse_next();
        check("uflow_set", underflow_err_o, 1'b1);
        repeat (3) @(negedge clk_i);
        check("uflow_sticky", underflow_err_o, 1'b1);
        rd_snap = rd_cnt;
        start_job(16'h0500, 9'd0);
        check("empty_done", done_o, 1'b1);
        check("uflow_clear", underflow_err_o, 1'b0);
        check("empty_rd_en", wmem_rd_en_o, 1'b0);
        @(negedge clk_i);
        check("empty_done_once", done_o, 1'b0);
        check("empty_no_reads", rd_cnt, rd_snap);

        // Address wrap from 0xFFF0
        start_job(16'hFFF0, 9'd1);
        for (int unsigned k = 0; k <= 31; k++) begin
            if (k > 0) @(negedge clk_i);
            ea = 16'hFFF0 + 16'(k);
            check("wrap_addr", wmem_addr_o, ea);
        end
        wait_rdy();
        pulse_next();
        wait_done();

`ifdef WEIGHT_PREFETCH_EN
        // Double buffered: three tiles, two fill back to back then hold
        start_job(16'h0400, 9'd3);
        for (int unsigned k = 0; k <= 70; k++) begin
            if (k > 0) @(negedge clk_i);
            check("pf_rd_en", wmem_rd_en_o, k <= 63);
            if (k <= 63) check("pf_addr", wmem_addr_o, 16'h0400 + k);
            check("pf_rdy", compute_weights_rdy_o, k >= 33);
            check("pf_bufsel", weight_buf_sel_o, (k >= 33) && (k < 65));
        end
        pulse_next();
        check("pf_hold_rd_en", wmem_rd_en_o, 1'b0);
        check("pf_rdy_one_left", compute_weights_rdy_o, 1'b1);
        @(negedge clk_i);
        check("pf_third_rd_en", wmem_rd_en_o, 1'b1);
        check("pf_third_addr", wmem_addr_o, 16'h0440);
        for (int unsigned k = 1; k <= 32; k++) @(negedge clk_i);
        check("pf_last_row_valid", weight_row_valid_o, 1'b1);
        check("pf_last_row_idx", weight_row_idx_o, 5'd31);
        next_weight_tile_i = 1'b1;
        @(negedge clk_i);
        next_weight_tile_i = 1'b0;
        check("pf_same_cycle_rdy", compute_weights_rdy_o, 1'b1);
        check("pf_same_cycle_uflow", underflow_err_o, 1'b0);
        pulse_next();
        check("pf_rdy_drained", compute_weights_rdy_o, 1'b0);
        wait_done();
`else
        // Single buffered: second tile waits until the first is freed
        start_job(16'h0200, 9'd2);
        for (int unsigned k = 0; k <= 40; k++) begin
            if (k > 0) @(negedge clk_i);
            check("sb_rd_en", wmem_rd_en_o, k <= 31);
            check("sb_rdy", compute_weights_rdy_o, k >= 33);
            check("sb_bufsel", weight_buf_sel_o, 1'b0);
        end
        pulse_next();
        check("sb_free_rd_en", wmem_rd_en_o, 1'b0);
        check("sb_free_rdy", compute_weights_rdy_o, 1'b0);
        @(negedge clk_i);
        check("sb_second_rd_en", wmem_rd_en_o, 1'b1);
        check("sb_second_addr", wmem_addr_o, 16'h0220);
        wait_rdy();
        pulse_next();
        wait_done();
`endif

        check("final_uflow", underflow_err_o, 1'b0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
